dmem_bus_if: RTL and testbench

- Data-side bus interface directly downstream of the memory-access stage.
- Converts that stage's single-cycle combinational request (ce/we/addr/sel/data) into a registered, ack-terminated bus transaction.
- Raises a pipeline stall request until the access completes, and returns the load data the stage samples on mem_data_i.
- Holds read data across downstream stalls and supports pipeline flush.

---
 rtl/dmem_bus_if.sv | 225 ++++++++++++++++++++++
 tb/tb_dmem_bus_if.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_bus_if.sv
// dmem_bus_if: data-side bus interface behind the memory-access stage.
// Turns the stage's single-cycle combinational request into a registered,
// ack-terminated bus transaction. It raises a stall request until the access
// completes and returns load data on cpu_data_o. Read data is held across
// downstream stalls, and a pipeline flush cancels the access.
// Optional feature: define DMEM_BUS_TIMEOUT_EN to abort a BUSY access that
// sees no ack within TIMEOUT_CYCLES cycles. The abort pulses bus_err_o.
module dmem_bus_if #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          stall_i,
  input  logic                flush_i,
  input  logic                cpu_ce_i,
  input  logic                cpu_we_i,
  input  logic [ADDR_W-1:0]   cpu_addr_i,
  input  logic [DATA_W/8-1:0] cpu_sel_i,
  input  logic [DATA_W-1:0]   cpu_data_i,
  output logic [DATA_W-1:0]   cpu_data_o,
  output logic                stallreq_o,
  output logic [ADDR_W-1:0]   bus_addr_o,
  output logic [DATA_W-1:0]   bus_data_o,
  output logic [DATA_W/8-1:0] bus_sel_o,
  output logic                bus_we_o,
  output logic                bus_cyc_o,
  output logic                bus_stb_o,
  input  logic [DATA_W-1:0]   bus_data_i,
  input  logic                bus_ack_i,
  output logic                bus_err_o
);

  localparam int SEL_W = DATA_W / 8;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_BUSY       = 2'd1,
    ST_WAIT_STALL = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next_state;

  logic [ADDR_W-1:0]   r_bus_addr;
  logic [DATA_W-1:0]   r_bus_data;
  logic [SEL_W-1:0]    r_bus_sel;
  logic                r_bus_we;
  logic                r_bus_cyc;
  logic                r_bus_stb;
  logic [DATA_W-1:0]   r_rd_buf;

  logic                w_start;
  logic                w_stalled;
  logic                w_timeout;
  logic                w_stallreq;
  logic [DATA_W-1:0]   w_cpu_data;

  // A request is accepted only from IDLE and only when no flush is present.
  assign w_start   = (r_state == ST_IDLE) && cpu_ce_i && !flush_i;
  assign w_stalled = |stall_i;

`ifdef DMEM_BUS_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8;

  logic [CNT_W-1:0] r_to_cnt;
  logic             r_bus_err;

  // The watchdog counts ack-free BUSY cycles. It sits at zero outside BUSY,
  // so every BUSY entry starts from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_to_cnt <= '0;
    end else if (r_state != ST_BUSY) begin
      r_to_cnt <= '0;
    end else if (!bus_ack_i) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  // The abort fires on the last allowed ack-free cycle. A same-cycle ack wins.
  assign w_timeout = (r_state == ST_BUSY) && !bus_ack_i &&
                     (r_to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // The error pulse is one cycle long. It follows an abort that no flush pre-empted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bus_err <= 1'b0;
    end else begin
      r_bus_err <= w_timeout && !flush_i;
    end
  end

  assign bus_err_o = r_bus_err;
`else
  // Without the watchdog, BUSY waits for an ack indefinitely.
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
  assign w_timeout        = 1'b0;
  assign bus_err_o        = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values, independent of block ordering.
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic and the combinational stall and load-data outputs.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    w_next_state = r_state;
    w_stallreq   = 1'b0;
    w_cpu_data   = '0;

    unique case (r_state)
      ST_IDLE: begin
        if (cpu_ce_i && !flush_i) begin
          w_stallreq   = 1'b1;
          w_next_state = ST_BUSY;
        end
      end

      ST_BUSY: begin
        if (flush_i) begin
          w_next_state = ST_IDLE;
        end else if (bus_ack_i) begin
          w_cpu_data   = bus_data_i;
          w_next_state = w_stalled ? ST_WAIT_STALL : ST_IDLE;
        end else if (w_timeout) begin
          w_next_state = w_stalled ? ST_WAIT_STALL : ST_IDLE;
        end else begin
          w_stallreq   = 1'b1;
        end
      end

      ST_WAIT_STALL: begin
        w_cpu_data = r_rd_buf;
        if (flush_i || !w_stalled) begin
          w_next_state = ST_IDLE;
        end
      end

      default: begin
        w_next_state = ST_IDLE;
      end
    endcase

    // Reset silences the pipeline-facing outputs within the same cycle.
    if (rst) begin
      w_next_state = ST_IDLE;
      w_stallreq   = 1'b0;
      w_cpu_data   = '0;
    end
  end

  // Bus-side registers and the read buffer. The request is latched only on
  // IDLE->BUSY, so the bus fields hold steady while the access is outstanding.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bus_addr <= '0;
      r_bus_data <= '0;
      r_bus_sel  <= '0;
      r_bus_we   <= 1'b0;
      r_bus_cyc  <= 1'b0;
      r_bus_stb  <= 1'b0;
      // NOTE: rd_buf is a single data register, not a memory array, and it is
      // visible in WAIT_STALL, so it gets a defined reset value.
      r_rd_buf   <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_bus_addr <= cpu_addr_i;
            r_bus_data <= cpu_data_i;
            r_bus_sel  <= cpu_sel_i;
            r_bus_we   <= cpu_we_i;
            r_bus_cyc  <= 1'b1;
            r_bus_stb  <= 1'b1;
          end
        end

        ST_BUSY: begin
          if (flush_i) begin
            r_bus_cyc <= 1'b0;
            r_bus_stb <= 1'b0;
            r_bus_we  <= 1'b0;
          end else if (bus_ack_i) begin
            r_bus_cyc <= 1'b0;
            r_bus_stb <= 1'b0;
            r_bus_we  <= 1'b0;
            if (!r_bus_we) begin
              r_rd_buf <= bus_data_i;
            end
          end else if (w_timeout) begin
            r_bus_cyc <= 1'b0;
            r_bus_stb <= 1'b0;
            r_bus_we  <= 1'b0;
            r_rd_buf  <= '0;
          end
        end

        default: begin
        end
      endcase
    end
  end

  assign cpu_data_o = w_cpu_data;
  assign stallreq_o = w_stallreq;
  assign bus_addr_o = r_bus_addr;
  assign bus_data_o = r_bus_data;
  assign bus_sel_o  = r_bus_sel;
  assign bus_we_o   = r_bus_we;
  assign bus_cyc_o  = r_bus_cyc;
  assign bus_stb_o  = r_bus_stb;

endmodule

// File: tb/tb_dmem_bus_if.sv
// Directed testbench for dmem_bus_if. Inputs change 1ns after the rising edge,
// and outputs are sampled 3ns after it.
module tb_dmem_bus_if;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  stall_i = '0;
  logic        flush_i = 1'b0;
  logic        cpu_ce_i = 1'b0;
  logic        cpu_we_i = 1'b0;
  logic [31:0] cpu_addr_i = '0;
  logic [3:0]  cpu_sel_i = '0;
  logic [31:0] cpu_data_i = '0;
  logic [31:0] cpu_data_o;
  logic        stallreq_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_data_o;
  logic [3:0]  bus_sel_o;
  logic        bus_we_o;
  logic        bus_cyc_o;
  logic        bus_stb_o;
  logic [31:0] bus_data_i = '0;
  logic        bus_ack_i = 1'b0;
  logic        bus_err_o;

  int n_tests = 0;
  int n_fail  = 0;

  dmem_bus_if #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .cpu_ce_i(cpu_ce_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
    .cpu_sel_i(cpu_sel_i), .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o),
    .stallreq_o(stallreq_o), .bus_addr_o(bus_addr_o), .bus_data_o(bus_data_o),
    .bus_sel_o(bus_sel_o), .bus_we_o(bus_we_o), .bus_cyc_o(bus_cyc_o),
    .bus_stb_o(bus_stb_o), .bus_data_i(bus_data_i), .bus_ack_i(bus_ack_i),
    .bus_err_o(bus_err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic drive_req(input logic we, input logic [31:0] addr,
                           input logic [3:0] sel, input logic [31:0] data);
    cpu_ce_i   = 1'b1;
    cpu_we_i   = we;
    cpu_addr_i = addr;
    cpu_sel_i  = sel;
    cpu_data_i = data;
  endtask

  task automatic drop_req();
    cpu_ce_i   = 1'b0;
    cpu_we_i   = 1'b0;
    cpu_addr_i = 32'hFFFF_FFF0;
    cpu_sel_i  = 4'hF;
    cpu_data_i = 32'hAAAA_AAAA;
  endtask

  // A store acked under a downstream stall makes WAIT_STALL expose rd_buf
  // without changing it.
  task automatic test_store_stall(input string name, input logic [31:0] exp_rd);
    drive_req(1'b1, 32'h0000_0070, 4'hF, 32'h5555_AAAA);
    settle();
    tick();
    drop_req();
    bus_ack_i  = 1'b1;
    bus_data_i = 32'h7777_7777;
    stall_i    = 6'b000001;
    settle();
    n_tests++;
    if (stallreq_o !== 1'b0) begin
      n_fail++; $display("FAIL %s_ack_stallreq: got %b want 0", name, stallreq_o);
    end
    tick();
    bus_ack_i = 1'b0;
    settle();
    n_tests++;
    if (cpu_data_o !== exp_rd) begin
      n_fail++; $display("FAIL %s_rdbuf: got %h want %h", name, cpu_data_o, exp_rd);
    end
    stall_i = '0;
    tick();
    settle();
    n_tests++;
    if (cpu_data_o !== 32'h0 || bus_cyc_o !== 1'b0) begin
      n_fail++; $display("FAIL %s_idle: got data %h cyc %b want 0/0", name, cpu_data_o, bus_cyc_o);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    settle();
    n_tests++;
    if ({bus_addr_o, bus_data_o, bus_sel_o, bus_we_o, bus_cyc_o, bus_stb_o, bus_err_o} !== '0) begin
      n_fail++; $display("FAIL reset_bus: got addr %h data %h sel %h we %b cyc %b stb %b err %b want all 0",
                         bus_addr_o, bus_data_o, bus_sel_o, bus_we_o, bus_cyc_o, bus_stb_o, bus_err_o);
    end
    drive_req(1'b0, 32'h0000_0004, 4'hF, 32'h0);
    bus_ack_i  = 1'b1;
    bus_data_i = 32'h1357_9BDF;
    settle();
    n_tests++;
    if (stallreq_o !== 1'b0 || cpu_data_o !== 32'h0) begin
      n_fail++; $display("FAIL reset_outputs: got stallreq %b data %h want 0/0", stallreq_o, cpu_data_o);
    end
    tick();
    rst       = 1'b0;
    bus_ack_i = 1'b0;
    drop_req();
    settle();
    n_tests++;
    if (bus_cyc_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_no_start: got cyc %b want 0", bus_cyc_o);
    end
    test_store_stall("reset_rdbuf", 32'h0);
  endtask

  task automatic test_read_fast();
    drive_req(1'b0, 32'h0000_0010, 4'hF, 32'h0);
    settle();
    n_tests++;
    if (stallreq_o !== 1'b1 || cpu_data_o !== 32'h0) begin
      n_fail++; $display("FAIL read_fast_req: got stallreq %b data %h want 1/0", stallreq_o, cpu_data_o);
    end
    tick();
    drop_req();
    bus_ack_i  = 1'b1;
    bus_data_i = 32'hDEAD_BEEF;
    settle();
    n_tests++;
    if ({bus_cyc_o, bus_stb_o, bus_we_o, bus_addr_o, bus_sel_o} !== {3'b110, 32'h0000_0010, 4'hF}) begin
      n_fail++; $display("FAIL read_fast_bus: got cyc %b stb %b we %b addr %h sel %h want 1 1 0 00000010 f",
                         bus_cyc_o, bus_stb_o, bus_we_o, bus_addr_o, bus_sel_o);
    end
    n_tests++;
    if (cpu_data_o !== 32'hDEAD_BEEF || stallreq_o !== 1'b0) begin
      n_fail++; $display("FAIL read_fast_ack: got data %h stallreq %b want deadbeef/0", cpu_data_o, stallreq_o);
    end
    tick();
    bus_ack_i = 1'b0;
    settle();
    n_tests++;
    if ({bus_cyc_o, bus_stb_o, stallreq_o} !== 3'b000 || cpu_data_o !== 32'h0) begin
      n_fail++; $display("FAIL read_fast_idle: got cyc %b stb %b stallreq %b data %h want 0 0 0 0",
                         bus_cyc_o, bus_stb_o, stallreq_o, cpu_data_o);
    end
  endtask

  task automatic test_store_wait();
    drive_req(1'b1, 32'h0000_0020, 4'b0011, 32'h0000_1234);
    settle();
    tick();
    drop_req();
    for (int i = 0; i < 4; i++) begin
      bus_ack_i = (i == 3);
      settle();
      n_tests++;
      if ({bus_we_o, bus_cyc_o, bus_stb_o, bus_addr_o, bus_sel_o, bus_data_o, stallreq_o} !==
          {3'b111, 32'h0000_0020, 4'b0011, 32'h0000_1234, (i != 3)}) begin
        n_fail++; $display("FAIL store_wait_cycle%0d: got we %b cyc %b stb %b addr %h sel %b data %h stallreq %b",
                           i, bus_we_o, bus_cyc_o, bus_stb_o, bus_addr_o, bus_sel_o, bus_data_o, stallreq_o);
      end
      tick();
    end
    bus_ack_i = 1'b0;
    settle();
    n_tests++;
    if ({bus_we_o, bus_cyc_o, bus_stb_o} !== 3'b000) begin
      n_fail++; $display("FAIL store_wait_end: got we %b cyc %b stb %b want 0 0 0", bus_we_o, bus_cyc_o, bus_stb_o);
    end
  endtask

  task automatic test_read_stall();
    drive_req(1'b0, 32'h0000_0030, 4'hF, 32'h0);
    settle();
    tick();
    drop_req();
    bus_ack_i  = 1'b1;
    bus_data_i = 32'hCAFE_0001;
    stall_i    = 6'b000011;
    settle();
    n_tests++;
    if (cpu_data_o !== 32'hCAFE_0001) begin
      n_fail++; $display("FAIL read_stall_ack: got %h want cafe0001", cpu_data_o);
    end
    tick();
    bus_ack_i  = 1'b0;
    bus_data_i = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      settle();
      n_tests++;
      if (cpu_data_o !== 32'hCAFE_0001 || stallreq_o !== 1'b0 || bus_cyc_o !== 1'b0) begin
        n_fail++; $display("FAIL read_stall_hold%0d: got data %h stallreq %b cyc %b want cafe0001 0 0",
                           i, cpu_data_o, stallreq_o, bus_cyc_o);
      end
      if (i == 2) stall_i = '0;
      tick();
    end
    settle();
    n_tests++;
    if (cpu_data_o !== 32'h0) begin
      n_fail++; $display("FAIL read_stall_release: got %h want 00000000", cpu_data_o);
    end
  endtask

  task automatic test_flush();
    // A flush in IDLE blocks the request.
    drive_req(1'b0, 32'h0000_0080, 4'hF, 32'h0);
    flush_i = 1'b1;
    settle();
    n_tests++;
    if (stallreq_o !== 1'b0) begin
      n_fail++; $display("FAIL flush_idle_stallreq: got %b want 0", stallreq_o);
    end
    tick();
    drop_req();
    flush_i = 1'b0;
    settle();
    n_tests++;
    if (bus_cyc_o !== 1'b0) begin
      n_fail++; $display("FAIL flush_idle_nostart: got cyc %b want 0", bus_cyc_o);
    end
    // A flush on the second wait cycle takes priority over a simultaneous ack.
    drive_req(1'b0, 32'h0000_0084, 4'hF, 32'h0);
    settle();
    tick();
    drop_req();
    settle();
    n_tests++;
    if (stallreq_o !== 1'b1) begin
      n_fail++; $display("FAIL flush_wait1_stallreq: got %b want 1", stallreq_o);
    end
    tick();
    flush_i    = 1'b1;
    bus_ack_i  = 1'b1;
    bus_data_i = 32'hBAD0_BAD0;
    settle();
    n_tests++;
    if (stallreq_o !== 1'b0 || cpu_data_o !== 32'h0) begin
      n_fail++; $display("FAIL flush_cycle: got stallreq %b data %h want 0/0", stallreq_o, cpu_data_o);
    end
    tick();
    flush_i = 1'b0;
    settle();
    n_tests++;
    if ({bus_cyc_o, bus_stb_o, bus_we_o, stallreq_o} !== 4'b0000 || cpu_data_o !== 32'h0) begin
      n_fail++; $display("FAIL flush_late_ack: got cyc %b stb %b we %b stallreq %b data %h want 0",
                         bus_cyc_o, bus_stb_o, bus_we_o, stallreq_o, cpu_data_o);
    end
    tick();
    bus_ack_i = 1'b0;
    test_store_stall("flush_rdbuf", 32'hCAFE_0001);
    // A flush in WAIT_STALL returns to IDLE even though the stall is still held.
    drive_req(1'b0, 32'h0000_0088, 4'hF, 32'h0);
    settle();
    tick();
    drop_req();
    bus_ack_i  = 1'b1;
    bus_data_i = 32'h0F0F_0F0F;
    stall_i    = 6'b000100;
    settle();
    tick();
    bus_ack_i = 1'b0;
    flush_i   = 1'b1;
    settle();
    n_tests++;
    if (cpu_data_o !== 32'h0F0F_0F0F) begin
      n_fail++; $display("FAIL flush_wait_stall_data: got %h want 0f0f0f0f", cpu_data_o);
    end
    tick();
    flush_i = 1'b0;
    settle();
    n_tests++;
    if (cpu_data_o !== 32'h0) begin
      n_fail++; $display("FAIL flush_wait_stall_exit: got %h want 00000000", cpu_data_o);
    end
    stall_i = '0;
    tick();
  endtask

  task automatic test_reset_mid();
    drive_req(1'b1, 32'h0000_0090, 4'b1100, 32'h9999_0000);
    settle();
    tick();
    drop_req();
    settle();
    n_tests++;
    if (bus_cyc_o !== 1'b1 || bus_we_o !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid_busy: got cyc %b we %b want 1/1", bus_cyc_o, bus_we_o);
    end
    rst = 1'b1;
    settle();
    n_tests++;
    if (stallreq_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_stallreq: got %b want 0", stallreq_o);
    end
    tick();
    rst        = 1'b0;
    bus_ack_i  = 1'b1;
    bus_data_i = 32'h5A5A_5A5A;
    settle();
    n_tests++;
    if ({bus_addr_o, bus_data_o, bus_sel_o, bus_we_o, bus_cyc_o, bus_stb_o, stallreq_o} !== '0 ||
        cpu_data_o !== 32'h0) begin
      n_fail++; $display("FAIL reset_mid_clear: got addr %h data %h sel %h we %b cyc %b stb %b stallreq %b cpu %h want 0",
                         bus_addr_o, bus_data_o, bus_sel_o, bus_we_o, bus_cyc_o, bus_stb_o, stallreq_o, cpu_data_o);
    end
    tick();
    bus_ack_i = 1'b0;
    drive_req(1'b0, 32'h0000_0040, 4'hF, 32'h0);
    settle();
    tick();
    drop_req();
    settle();
    tick();
    bus_ack_i  = 1'b1;
    bus_data_i = 32'h0BAD_F00D;
    settle();
    n_tests++;
    if (cpu_data_o !== 32'h0BAD_F00D || bus_addr_o !== 32'h0000_0040) begin
      n_fail++; $display("FAIL reset_mid_new_read: got data %h addr %h want 0badf00d 00000040", cpu_data_o, bus_addr_o);
    end
    tick();
    bus_ack_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    drive_req(1'b0, 32'h0000_0050, 4'hF, 32'h0);
    settle();
    tick();
    drop_req();
    bus_ack_i  = 1'b1;
    bus_data_i = 32'h1111_1111;
    settle();
    tick();
    bus_ack_i = 1'b0;
    drive_req(1'b1, 32'h0000_0054, 4'b0101, 32'h2222_2222);
    settle();
    n_tests++;
    if (stallreq_o !== 1'b1) begin
      n_fail++; $display("FAIL b2b_accept: got stallreq %b want 1", stallreq_o);
    end
    tick();
    drop_req();
    bus_ack_i = 1'b1;
    settle();
    n_tests++;
    if ({bus_cyc_o, bus_we_o, bus_addr_o, bus_sel_o, bus_data_o} !== {2'b11, 32'h0000_0054, 4'b0101, 32'h2222_2222}) begin
      n_fail++; $display("FAIL b2b_second_bus: got cyc %b we %b addr %h sel %b data %h",
                         bus_cyc_o, bus_we_o, bus_addr_o, bus_sel_o, bus_data_o);
    end
    tick();
    bus_ack_i = 1'b0;
  endtask

`ifdef DMEM_BUS_TIMEOUT_EN
  task automatic test_timeout();
    drive_req(1'b0, 32'h0000_0060, 4'hF, 32'h0);
    settle();
    tick();
    drop_req();
    bus_data_i = 32'h9999_9999;
    for (int i = 0; i < 4; i++) begin
      settle();
      n_tests++;
      if (bus_stb_o !== 1'b1 || bus_err_o !== 1'b0 || stallreq_o !== (i != 3) || cpu_data_o !== 32'h0) begin
        n_fail++; $display("FAIL timeout_cycle%0d: got stb %b err %b stallreq %b data %h",
                           i, bus_stb_o, bus_err_o, stallreq_o, cpu_data_o);
      end
      tick();
    end
    settle();
    n_tests++;
    if ({bus_stb_o, bus_cyc_o, bus_err_o, stallreq_o} !== 4'b0010) begin
      n_fail++; $display("FAIL timeout_abort: got stb %b cyc %b err %b stallreq %b want 0 0 1 0",
                         bus_stb_o, bus_cyc_o, bus_err_o, stallreq_o);
    end
    tick();
    settle();
    n_tests++;
    if (bus_err_o !== 1'b0) begin
      n_fail++; $display("FAIL timeout_pulse: got err %b want 0", bus_err_o);
    end
    test_store_stall("timeout_rdbuf", 32'h0);
  endtask
`endif

  initial begin
    test_reset();
    test_read_fast();
    test_store_wait();
    test_read_stall();
    test_store_stall("write_keeps_rdbuf", 32'hCAFE_0001);
    test_flush();
    test_reset_mid();
    test_back_to_back();
`ifdef DMEM_BUS_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
